// File: rtl/pulsador_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulsador_debounce_pkg
//  Description : Shared board timing constants for pushbutton handling and a
//                helper giving the idle (released) raw level of a button.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulsador_debounce_pkg;

    // About 1.3 ms of stable samples at the board clock to accept a level.
    localparam int unsigned c_DEBOUNCE_CYCLES = 32'd65536;

    // About 280 ms of continuous press before a hold event is raised.
    localparam int unsigned c_HOLD_CYCLES     = 32'd14000000;

    // Raw pin level seen while the button is not pressed.
    function automatic logic released_level(input logic active_low);
        return active_low;
    endfunction

endpackage : pulsador_debounce_pkg
`default_nettype wire

// File: rtl/pulsador_debounce_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input, with
//                a configurable value loaded on reset so that a button input
//                can come out of reset already at its idle level.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pulsador_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pulsador_debounce
//  Description : Pushbutton conditioner: synchronizes and debounces a bouncing
//                raw input, provides a clean pressed level, one-cycle press,
//                release and long-press (hold) strobes, and a held level.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulsador_debounce
    import pulsador_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = c_HOLD_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_raw,
    output logic pulsador,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic held
);

    localparam int unsigned c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned c_HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_PRESSED      = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    logic                w_raw_sync;
    logic                w_s;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_DB_W-1:0]   w_db_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
    logic                w_press_acc;
    logic                w_release_acc;
    logic                w_hold_fire;
    logic                w_pressed_nxt;
    logic                r_pulsador;
    logic                r_press_pulse;
    logic                r_release_pulse;
    logic                r_hold_pulse;
    logic                r_held;

    sync_2ff #(
        .RESET_VALUE (released_level(ACTIVE_LOW))
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (boton_raw),
        .o_q (w_raw_sync)
    );

    // Normalized sample: 1 means pressed regardless of pin polarity.
    assign w_s = ACTIVE_LOW ? ~w_raw_sync : w_raw_sync;

    // Debounce FSM next state: a level is accepted only after the sample has
    // stayed at the new value while the counter walks up to its last value.
    always_comb begin
        w_state_nxt   = r_state;
        w_db_cnt_nxt  = r_db_cnt;
        w_press_acc   = 1'b0;
        w_release_acc = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt  = c_ST_PRESS_WAIT;
                    w_db_cnt_nxt = '0;
                end
            end
            c_ST_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt  = c_ST_PRESSED;
                    w_press_acc  = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            c_ST_PRESSED: begin
                if (!w_s) begin
                    w_state_nxt  = c_ST_RELEASE_WAIT;
                    w_db_cnt_nxt = '0;
                end
            end
            c_ST_RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt   = c_ST_PRESSED;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_release_acc = 1'b1;
                end else begin
                    w_db_cnt_nxt  = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = c_ST_IDLE;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    // Hold timing: restart on each accepted press, saturate at the threshold,
    // fire once; a release accepted on the same cycle suppresses the event.
    always_comb begin
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_fire    = 1'b0;
        if (w_press_acc) begin
            w_hold_cnt_nxt = '0;
        end else if ((r_state == c_ST_PRESSED) || (r_state == c_ST_RELEASE_WAIT)) begin
            if (r_hold_cnt != c_HOLD_LAST) begin
                w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end else if (!r_held && !w_release_acc) begin
                w_hold_fire = 1'b1;
            end
        end
    end

    assign w_pressed_nxt = (w_state_nxt == c_ST_PRESSED) ||
                           (w_state_nxt == c_ST_RELEASE_WAIT);

    // State, counters and registered outputs, all updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_pulsador      <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_hold_pulse    <= 1'b0;
            r_held          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_db_cnt        <= w_db_cnt_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_pulsador      <= w_pressed_nxt;
            r_press_pulse   <= w_press_acc;
            r_release_pulse <= w_release_acc;
            r_hold_pulse    <= w_hold_fire;
            if (w_release_acc) begin
                r_held <= 1'b0;
            end else if (w_hold_fire) begin
                r_held <= 1'b1;
            end
        end
    end

    assign pulsador      = r_pulsador;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign hold_pulse    = r_hold_pulse;
    assign held          = r_held;

endmodule : pulsador_debounce
`default_nettype wire

// File: tb/tb_pulsador_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulsador_debounce
//  Description : Self-checking bench for pulsador_debounce with a run-length
//                reference model, directed timing scenarios and random
//                stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulsador_debounce;

    localparam int c_DB   = 8;
    localparam int c_HOLD = 32;

    logic clk;
    logic rst;
    logic boton_raw;
    logic pulsador;
    logic press_pulse;
    logic release_pulse;
    logic hold_pulse;
    logic held;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model state: raw delay line, accepted level, run length of
    // samples disagreeing with the level, cycles since press, held flag.
    logic m_d1 = 1'b1;
    logic m_d2 = 1'b1;
    logic m_level = 1'b0;
    int   m_run = 0;
    int   m_age = 0;
    logic m_held = 1'b0;
    logic m_press = 1'b0;
    logic m_rel = 1'b0;
    logic m_hold = 1'b0;

    // Events observed on the DUT, per scenario.
    int   n_press, n_rel, n_hold;
    int   t_press, t_rel, t_hold;
    logic held_seen;

    pulsador_debounce #(
        .DEBOUNCE_CYCLES (c_DB),
        .HOLD_CYCLES     (c_HOLD),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .boton_raw     (boton_raw),
        .pulsador      (pulsador),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse),
        .held          (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock edge of the behavioural model.
    task automatic model_edge(input logic raw_v, input logic rst_v);
        logic s;
        logic prev;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_hold  = 1'b0;
        if (rst_v) begin
            m_d1 = 1'b1; m_d2 = 1'b1;
            m_level = 1'b0; m_run = 0; m_age = 0; m_held = 1'b0;
        end else begin
            s    = (m_d2 == 1'b0);
            m_d2 = m_d1;
            m_d1 = raw_v;
            prev = m_level;
            if (s != m_level) begin
                m_run++;
                if (m_run == c_DB + 1) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    if (m_level) begin
                        m_press = 1'b1;
                        m_age   = 0;
                    end else begin
                        m_rel  = 1'b1;
                        m_held = 1'b0;
                    end
                end
            end else begin
                m_run = 0;
            end
            if (prev && m_level) begin
                m_age++;
                if (m_age >= c_HOLD && !m_held) begin
                    m_hold = 1'b1;
                    m_held = 1'b1;
                end
            end
        end
    endtask

    task automatic tick(input logic raw_v, input logic rst_v);
        @(negedge clk);
        boton_raw = raw_v;
        rst       = rst_v;
        @(posedge clk);
        cyc++;
        model_edge(raw_v, rst_v);
        #1;
        check_eq("pulsador", pulsador, m_level);
        check_eq("press_pulse", press_pulse, m_press);
        check_eq("release_pulse", release_pulse, m_rel);
        check_eq("hold_pulse", hold_pulse, m_hold);
        check_eq("held", held, m_held);
        if (press_pulse)   begin n_press++; t_press = cyc; end
        if (release_pulse) begin n_rel++;   t_rel   = cyc; end
        if (hold_pulse)    begin n_hold++;  t_hold  = cyc; end
        if (held)          held_seen = 1'b1;
    endtask

    task automatic clear_events();
        n_press = 0; n_rel = 0; n_hold = 0;
        t_press = -1; t_rel = -1; t_hold = -1;
        held_seen = 1'b0;
    endtask

    task automatic ticks(input logic raw_v, input int n);
        for (int i = 0; i < n; i++) tick(raw_v, 1'b0);
    endtask

    initial begin
        int t0;
        int t1;
        int seg_val;
        int seg_len;
        rst       = 1'b1;
        boton_raw = 1'b1;
        clear_events();

        // Reset state
        tick(1'b1, 1'b1);
        check_eq("rst_pulsador", pulsador, 0);
        check_eq("rst_held", held, 0);
        tick(1'b1, 1'b1);
        ticks(1'b1, 5);

        // Clean press then clean release
        clear_events();
        tick(1'b0, 1'b0); t0 = cyc;
        ticks(1'b0, 14);
        check_eq("clean_press_cnt", n_press, 1);
        check_eq("clean_press_t", t_press, t0 + 10);
        tick(1'b1, 1'b0); t1 = cyc;
        ticks(1'b1, 14);
        check_eq("clean_rel_cnt", n_rel, 1);
        check_eq("clean_rel_t", t_rel, t1 + 10);

        // Bounce: 3-cycle toggles for 30 cycles, then settle pressed
        clear_events();
        for (int seg = 0; seg < 10; seg++) begin
            for (int k = 0; k < 3; k++) tick(((seg % 2) == 1), 1'b0);
        end
        tick(1'b0, 1'b0); t0 = cyc;
        ticks(1'b0, 19);
        check_eq("bounce_press_cnt", n_press, 1);
        check_eq("bounce_press_t", t_press, t0 + 10);
        ticks(1'b1, 15);

        // Long press with hold
        clear_events();
        tick(1'b0, 1'b0); t0 = cyc;
        ticks(1'b0, 59);
        check_eq("long_press_t", t_press, t0 + 10);
        check_eq("long_hold_cnt", n_hold, 1);
        check_eq("long_hold_t", t_hold, t0 + 42);
        check_eq("long_held_lvl", held, 1);
        tick(1'b1, 1'b0); t1 = cyc;
        ticks(1'b1, 14);
        check_eq("long_rel_t", t_rel, t1 + 10);
        check_eq("long_held_after", held, 0);

        // Short press: nothing accepted
        clear_events();
        ticks(1'b0, 5);
        ticks(1'b1, 15);
        check_eq("short_press_cnt", n_press, 0);
        check_eq("short_rel_cnt", n_rel, 0);
        check_eq("short_pulsador", pulsador, 0);

        // Reset while pressed
        ticks(1'b0, 14);
        check_eq("pre_rst_pulsador", pulsador, 1);
        clear_events();
        tick(1'b0, 1'b1); t0 = cyc;
        check_eq("rst_mid_pulsador", pulsador, 0);
        check_eq("rst_mid_release", release_pulse, 0);
        ticks(1'b0, 15);
        check_eq("rst_mid_rel_cnt", n_rel, 0);
        check_eq("rst_mid_press_t", t_press, t0 + 11);
        ticks(1'b1, 15);

        // Release acceptance lands on the hold threshold cycle
        clear_events();
        tick(1'b0, 1'b0); t0 = cyc;
        ticks(1'b0, 31);
        ticks(1'b1, 15);
        check_eq("coinc_press_t", t_press, t0 + 10);
        check_eq("coinc_rel_t", t_rel, t0 + 42);
        check_eq("coinc_hold_cnt", n_hold, 0);
        check_eq("coinc_held_seen", held_seen, 0);

        // Random runs of raw levels with occasional resets
        for (int n = 0; n < 200; n++) begin
            seg_val = $urandom_range(0, 1);
            seg_len = $urandom_range(1, 48);
            for (int k = 0; k < seg_len; k++)
                tick(seg_val[0], ($urandom_range(0, 249) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pulsador_debounce
`default_nettype wire
